// File: rtl/size_convert.sv
// size_convert -- byte-to-word packer.
//
// Collects strobed bytes little-endian into SIZE-bit words. The first N-1
// bytes of a word sit in an internal packing buffer; the N-th byte is merged
// straight from DATA_IN into DATA_OUT, so the word appears one edge after
// its last byte is strobed. There is no handshake or backpressure.
//
// Ports:
//   PCLK           in   clock, all state on rising edge
//   RESET          in   synchronous active-high reset (wins over strobe)
//   BIT_RATE_CLK10 in   byte strobe, DATA_IN valid when 1
//   DATA_IN[7:0]   in   incoming byte
//   DATA_OUT       out  last completed word (SIZE bits), registered
//   IDLE_BUFFER    out  registered: packer was empty and no byte accepted
module size_convert #(
  parameter int SIZE = 8
) (
  input  logic            PCLK,
  input  logic            RESET,
  input  logic            BIT_RATE_CLK10,
  input  logic [7:0]      DATA_IN,
  output logic [SIZE-1:0] DATA_OUT,
  output logic            IDLE_BUFFER
);

  localparam int N  = SIZE / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] dout_q, dout_d;
  logic            idle_q, idle_d;
  logic            last_w;
  logic [SIZE-1:0] word_w;

  assign last_w = (cnt_q == LAST);

  // Packing buffer only exists when a word spans more than one byte.
  if (N > 1) begin : g_pack
    logic [(N-1)*8-1:0] buf_q, buf_d;

    always_comb begin
      buf_d = buf_q;
      for (int l = 0; l < N - 1; l++) begin
        if (BIT_RATE_CLK10 && !last_w && (cnt_q == CW'(l)))
          buf_d[l*8 +: 8] = DATA_IN;
      end
    end

    always_ff @(posedge PCLK) begin
      if (RESET) buf_q <= '0;
      else       buf_q <= buf_d;
    end

    // Final byte bypasses the buffer into the top lane.
    assign word_w = {DATA_IN, buf_q};
  end else begin : g_byte
    assign word_w = DATA_IN;
  end

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    // Uses the pre-edge count, so a mid-word gap keeps IDLE_BUFFER low.
    idle_d = !BIT_RATE_CLK10 && (cnt_q == '0);
    if (BIT_RATE_CLK10) begin
      if (last_w) begin
        cnt_d  = '0;
        dout_d = word_w;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      dout_q <= '0;
      idle_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      idle_q <= idle_d;
    end
  end

  assign DATA_OUT    = dout_q;
  assign IDLE_BUFFER = idle_q;

endmodule

// File: tb/tb_size_convert.sv
// Bench for size_convert: three instances (SIZE 8/16/32) share one stimulus
// stream. A byte-list model predicts every output each cycle; directed
// literal checks pin the model to hand-computed values.
module tb_size_convert;

  logic        PCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stb = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout8;
  logic [15:0] dout16;
  logic [31:0] dout32;
  logic [2:0]  idle;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  always #5 PCLK = ~PCLK;

  size_convert #(.SIZE(8))  u8  (.PCLK(PCLK), .RESET(RESET), .BIT_RATE_CLK10(stb),
                                 .DATA_IN(din), .DATA_OUT(dout8),  .IDLE_BUFFER(idle[0]));
  size_convert #(.SIZE(16)) u16 (.PCLK(PCLK), .RESET(RESET), .BIT_RATE_CLK10(stb),
                                 .DATA_IN(din), .DATA_OUT(dout16), .IDLE_BUFFER(idle[1]));
  size_convert #(.SIZE(32)) u32 (.PCLK(PCLK), .RESET(RESET), .BIT_RATE_CLK10(stb),
                                 .DATA_IN(din), .DATA_OUT(dout32), .IDLE_BUFFER(idle[2]));

  logic [31:0] dout_a [3];
  assign dout_a[0] = {24'h0, dout8};
  assign dout_a[1] = {16'h0, dout16};
  assign dout_a[2] = dout32;

  // Model: per size, a list of bytes received so far in the current word.
  int          nbytes_m [3];
  logic [7:0]  bytes_m  [3][4];
  logic [31:0] word_m   [3];
  logic        idle_m   [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      nbytes_m[k] = 0;
      word_m[k]   = 0;
      idle_m[k]   = 1'b1;
    end
  end

  always @(posedge PCLK) begin
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 1 << k;
      if (RESET) begin
        nbytes_m[k] = 0;
        word_m[k]   = 0;
        idle_m[k]   = 1'b1;
      end else begin
        idle_m[k] = !stb && (nbytes_m[k] == 0);
        if (stb) begin
          bytes_m[k][nbytes_m[k]] = din;
          nbytes_m[k] = nbytes_m[k] + 1;
          if (nbytes_m[k] == n) begin
            word_m[k] = 0;
            for (int i = 0; i < n; i++)
              word_m[k] = word_m[k] + (32'(bytes_m[k][i]) << (8 * i));
            nbytes_m[k] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge PCLK) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_dout[%0d]", 8 << k), dout_a[k], word_m[k]);
        chk($sformatf("model_idle[%0d]", 8 << k), {31'h0, idle[k]}, {31'h0, idle_m[k]});
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [7:0] d);
    RESET = r;
    stb   = s;
    din   = d;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    // Reset
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    started = 1;
    chk("rst_dout8", {24'h0, dout8}, 32'h0);
    chk("rst_dout16", {16'h0, dout16}, 32'h0);
    chk("rst_dout32", dout32, 32'h0);
    chk("rst_idle", {29'h0, idle}, 32'h7);

    // SIZE=8 pass-through
    step(0, 1, 8'hA5);
    chk("s8_first", {24'h0, dout8}, 32'hA5);
    chk("s8_idle_busy", {31'h0, idle[0]}, 32'h0);
    step(0, 1, 8'h3C);
    chk("s8_second", {24'h0, dout8}, 32'h3C);
    chk("s16_pair", {16'h0, dout16}, 32'h3CA5);
    step(0, 0, 8'h00);
    chk("s8_idle_after", {31'h0, idle[0]}, 32'h1);
    chk("s32_idle_partial", {31'h0, idle[2]}, 32'h0);

    // SIZE=16 packing from a clean state
    step(1, 0, 8'h00);
    step(0, 1, 8'h34);
    chk("s16_half", {16'h0, dout16}, 32'h0);
    chk("s16_idle_b1", {31'h0, idle[1]}, 32'h0);
    step(0, 1, 8'h12);
    chk("s16_word", {16'h0, dout16}, 32'h1234);
    chk("s16_idle_b2", {31'h0, idle[1]}, 32'h0);

    // SIZE=32 with an idle gap mid-word
    step(1, 0, 8'h00);
    step(0, 1, 8'h78);
    step(0, 1, 8'h56);
    step(0, 0, 8'h00);
    chk("s32_gap_idle", {31'h0, idle[2]}, 32'h0);
    chk("s32_gap_dout", dout32, 32'h0);
    step(0, 1, 8'h34);
    chk("s32_3rd", dout32, 32'h0);
    step(0, 1, 8'h12);
    chk("s32_word", dout32, 32'h12345678);

    // Reset mid-word discards partial bytes
    step(0, 1, 8'h11);
    step(0, 1, 8'h22);
    step(1, 0, 8'h00);
    chk("s32_rst_mid", dout32, 32'h0);
    step(0, 1, 8'hAA);
    step(0, 1, 8'hBB);
    step(0, 1, 8'hCC);
    step(0, 1, 8'hDD);
    chk("s32_after_rst", dout32, 32'hDDCCBBAA);

    // Reset beats strobe
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'hFF);
      chk("rst_stb_dout32", dout32, 32'h0);
      chk("rst_stb_dout8", {24'h0, dout8}, 32'h0);
      chk("rst_stb_idle", {29'h0, idle}, 32'h7);
    end

    // Completed word then a long quiet stretch
    step(0, 1, 8'h01);
    step(0, 1, 8'h02);
    step(0, 1, 8'h03);
    step(0, 1, 8'h04);
    chk("hold_word32", dout32, 32'h04030201);
    chk("hold_word16", {16'h0, dout16}, 32'h0403);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'h5A);
      chk("hold_dout32", dout32, 32'h04030201);
      chk("hold_dout8", {24'h0, dout8}, 32'h04);
      chk("hold_idle", {29'h0, idle}, 32'h7);
    end

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, 8'($urandom));
    step(0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
